seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_mult_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier controller driving one shared external WIDTH-bit adder.
// Optional early termination on an all-zero remaining multiplier: define SEQ_MULT_EARLY_TERM_EN.
//
//   state  | meaning
//   S_IDLE | waiting for start, adder operands forced to 0
//   S_RUN  | one partial-product step per cycle
//   S_DONE | one-cycle done pulse, p freshly written; start here restarts
module seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   m, m_nx;
   logic [WIDTH-1:0]   h, h_nx;
   logic [WIDTH-1:0]   q, q_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [2*WIDTH-1:0] p_nx;

   logic [WIDTH:0]     step_c;
   logic [WIDTH-1:0]   step_h;
   logic [WIDTH-1:0]   step_q;
   logic [CW-1:0]      cnt_inc;

`ifdef SEQ_MULT_EARLY_TERM_EN
   logic [CW-1:0]      r_left;
   logic               low_zero;
   logic [2*WIDTH-1:0] et_p;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         m     <= '0;
         h     <= '0;
         q     <= '0;
         cnt   <= '0;
         p     <= '0;
      end else begin
         state <= state_nx;
         m     <= m_nx;
         h     <= h_nx;
         q     <= q_nx;
         cnt   <= cnt_nx;
         p     <= p_nx;
      end
   end

   // Step result: carry and sum form the new top, then {H,Q} shifts right by one.
   always_comb begin
      step_c  = q[0] ? {add_cout, add_sum} : {1'b0, h};
      step_h  = step_c[WIDTH:1];
      step_q  = {step_c[0], q[WIDTH-1:1]};
      cnt_inc = cnt + CW'(1);
   end

`ifdef SEQ_MULT_EARLY_TERM_EN
   // After this step, the low r_left bits of step_q are still unconsumed multiplier bits.
   always_comb begin
      r_left   = CW'(WIDTH) - cnt_inc;
      low_zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if ((CW'(i) < r_left) && step_q[i]) low_zero = 1'b0;
      end
      et_p = {step_h, step_q} >> r_left;
   end
`endif

   always_comb begin
      state_nx = state;
      m_nx     = m;
      h_nx     = h;
      q_nx     = q;
      cnt_nx   = cnt;
      p_nx     = p;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               m_nx     = a;
               h_nx     = '0;
               q_nx     = b;
               cnt_nx   = '0;
               state_nx = S_RUN;
            end else if (state == S_DONE) begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            h_nx   = step_h;
            q_nx   = step_q;
            cnt_nx = cnt_inc;
            if (cnt == CW'(WIDTH - 1)) begin
               p_nx     = {step_h, step_q};
               state_nx = S_DONE;
            end
`ifdef SEQ_MULT_EARLY_TERM_EN
            else if (low_zero) begin
               p_nx     = et_p;
               state_nx = S_DONE;
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);
   assign add_a = busy ? h : '0;
   assign add_b = (busy && q[0]) ? m : '0;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl (WIDTH=8) with a behavioural model of the shared adder.
module tb_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy, done;
   logic [15:0] p;
   logic [7:0]  add_a, add_b, add_sum;
   logic        add_cout;

   int checks = 0;
   int errors = 0;
   int n;

   seq_mult_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .p(p),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat_of(input logic [7:0] bv);
      int l;
      l = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
      l = 1;
      for (int i = 0; i < 8; i++) if (bv[i]) l = i + 1;
`endif
      return l;
   endfunction

   // Runs until done (bounded), checking busy, adder operands and that p holds its old value.
   task automatic wait_done(input logic [7:0] ia, input logic [7:0] ib,
                            input logic [15:0] hold_p, output int cyc);
      int hk;
      cyc = 0;
      while (!done && cyc < 20) begin
         chk("busy_run", {31'b0, busy}, 32'd1);
         chk("p_hold", {16'b0, p}, {16'b0, hold_p});
         if (cyc < 8) begin
            hk = (int'(ia) * (int'(ib) % (1 << cyc))) >> cyc;
            chk("add_a", {24'b0, add_a}, hk);
            chk("add_b", {24'b0, add_b}, ib[cyc] ? {24'b0, ia} : 32'd0);
         end
         tick();
         cyc++;
      end
   endtask

   task automatic run(input logic [7:0] ia, input logic [7:0] ib,
                      input logic [15:0] hold_p, input logic [15:0] exp_p, input string tag);
      int c;
      a = ia;
      b = ib;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(ia, ib, hold_p, c);
      chk({tag, "_lat"}, c, lat_of(ib));
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      chk({tag, "_p"}, {16'b0, p}, {16'b0, exp_p});
      tick();
      chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      chk({tag, "_p_held"}, {16'b0, p}, {16'b0, exp_p});
   endtask

   initial begin
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_p", {16'b0, p}, 32'd0);
      chk("rst_add_a", {24'b0, add_a}, 32'd0);
      chk("rst_add_b", {24'b0, add_b}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run(8'd13, 8'd11, 16'd0, 16'd143, "m13x11");
      run(8'd255, 8'd255, 16'd143, 16'd65025, "m255x255");
      run(8'd200, 8'd0, 16'd65025, 16'd0, "m200x0");
      run(8'd77, 8'd1, 16'd0, 16'd77, "m77x1");

      // start pulses at run cycles 3 and 5 must be ignored
      a = 8'd20;
      b = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         chk("ign_p_hold", {16'b0, p}, 32'd77);
         if (n == 3 || n == 5) begin
            a = 8'd99;
            b = 8'd99;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk("ign_lat", n, lat_of(8'd200));
      chk("ign_p", {16'b0, p}, 32'd4000);
      tick();
      chk("ign_single_done", {31'b0, done}, 32'd0);
      chk("ign_no_restart", {31'b0, busy}, 32'd0);

      // reset in the middle of a run
      a = 8'd255;
      b = 8'd255;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_p", {16'b0, p}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      run(8'd6, 8'd7, 16'd0, 16'd42, "m6x7");

      // back-to-back with start held high
      a = 8'd3;
      b = 8'd5;
      start = 1'b1;
      tick();
      wait_done(8'd3, 8'd5, 16'd42, n);
      chk("b2b1_lat", n, lat_of(8'd5));
      chk("b2b1_done", {31'b0, done}, 32'd1);
      chk("b2b1_p", {16'b0, p}, 32'd15);
      a = 8'd9;
      b = 8'd9;
      tick();
      wait_done(8'd9, 8'd9, 16'd15, n);
      chk("b2b2_lat", n, lat_of(8'd9));
      chk("b2b2_done", {31'b0, done}, 32'd1);
      chk("b2b2_p", {16'b0, p}, 32'd81);
      a = 8'd100;
      b = 8'd3;
      tick();
      wait_done(8'd100, 8'd3, 16'd81, n);
      chk("b2b3_lat", n, lat_of(8'd3));
      chk("b2b3_done", {31'b0, done}, 32'd1);
      chk("b2b3_p", {16'b0, p}, 32'd300);
      start = 1'b0;
      tick();
      chk("b2b_end_done", {31'b0, done}, 32'd0);
      chk("b2b_end_busy", {31'b0, busy}, 32'd0);
      chk("b2b_end_p", {16'b0, p}, 32'd300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
